// File: rtl/barcode_tx_if.sv
// barcode_tx_if: request/data and serial line bundle for barcode_tx.
// The master drives frame requests; the slave returns the serial line and status.
interface barcode_tx_if;
  logic        send;
  logic [7:0]  ID;
  logic [21:0] period;
  logic        BC;
  logic        busy;
  logic        tx_done;

  modport master (
    output send, ID, period,
    input  BC, busy, tx_done
  );

  modport slave (
    input  send, ID, period,
    output BC, busy, tx_done
  );
endinterface

// File: rtl/barcode_tx.sv
// barcode_tx: serial barcode frame generator.
// One start bit then 8 pulse-width coded data bits, MSB first.
module barcode_tx (
  input  logic        clk,
  input  logic        rst_n,
  barcode_tx_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    START_LO,
    START_HI,
    BIT_LO,
    BIT_HI
  } state_t;

  state_t      state;
  logic [21:0] timer;
  logic [21:0] pe_q;
  logic [21:0] pe_raw;
  logic [21:0] pe_in;
  logic [21:0] half_in;
  logic [21:0] half_q;
  logic [21:0] qtr_q;
  logic [21:0] tq_q;
  logic [2:0]  bit_idx;
  logic [2:0]  nxt_idx;
  logic [7:0]  id_q;
  logic        bc;
  logic        busy;
  logic        tx_done;
  logic        expired;

  // Period is truncated to a multiple of 4 so all phase lengths are exact.
  assign pe_raw  = bus.period & ~22'd3;
  assign pe_in   = (pe_raw < 22'd16) ? 22'd16 : pe_raw;
  assign half_in = pe_in >> 1;
  assign half_q  = pe_q >> 1;
  assign qtr_q   = pe_q >> 2;
  assign tq_q    = half_q + qtr_q;
  assign nxt_idx = bit_idx - 3'd1;
  assign expired = (timer == '0);

  assign bus.BC      = bc;
  assign bus.busy    = busy;
  assign bus.tx_done = tx_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= 3'd7;
      id_q    <= '0;
      pe_q    <= 22'd16;
      bc      <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.send) begin
            id_q    <= bus.ID;
            pe_q    <= pe_in;
            timer   <= half_in - 22'd1;
            bit_idx <= 3'd7;
            bc      <= 1'b0;
            busy    <= 1'b1;
            state   <= START_LO;
          end
        end
        START_LO: begin
          if (expired) begin
            state <= START_HI;
            bc    <= 1'b1;
            timer <= half_q - 22'd1;
          end else begin
            timer <= timer - 22'd1;
          end
        end
        START_HI: begin
          if (expired) begin
            state <= BIT_LO;
            bc    <= 1'b0;
            timer <= id_q[bit_idx] ? qtr_q - 22'd1 : tq_q - 22'd1;
          end else begin
            timer <= timer - 22'd1;
          end
        end
        BIT_LO: begin
          if (expired) begin
            state <= BIT_HI;
            bc    <= 1'b1;
            timer <= id_q[bit_idx] ? tq_q - 22'd1 : qtr_q - 22'd1;
          end else begin
            timer <= timer - 22'd1;
          end
        end
        BIT_HI: begin
          if (expired) begin
            if (bit_idx == 3'd0) begin
              state   <= IDLE;
              busy    <= 1'b0;
              tx_done <= 1'b1;
              bit_idx <= 3'd7;
            end else begin
              state   <= BIT_LO;
              bc      <= 1'b0;
              bit_idx <= nxt_idx;
              timer   <= id_q[nxt_idx] ? qtr_q - 22'd1 : tq_q - 22'd1;
            end
          end else begin
            timer <= timer - 22'd1;
          end
        end
        default: begin
          state <= IDLE;
          bc    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_barcode_tx.sv
// tb_barcode_tx: scoreboard bench for barcode_tx.
// Expected segments are queued at send time and compared as the line toggles.
module tb_barcode_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  barcode_tx_if bus ();

  barcode_tx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic lvl;
    int   len;
  } seg_t;

  seg_t       exp_q[$];
  logic [7:0] rx_q[$];
  seg_t       e;
  int         n_pass = 0;
  int         n_chk = 0;
  int         run_len = 0;
  logic       run_bc = 1'b1;
  bit         in_frame = 0;
  bit         close_seg;
  int         seg_idx = 0;
  int         start_lo = 0;
  logic [7:0] rx_sh = '0;

  // Line monitor, scoreboard and a simple width-comparing receiver.
  always @(negedge clk) begin
    close_seg = 0;
    if (!rst_n) begin
      in_frame = 0;
    end else begin
      if (in_frame && (!bus.busy || bus.BC !== run_bc))
        close_seg = 1;
      if (close_seg) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL seg%0d unexpected: lvl=%0b len=%0d", seg_idx, run_bc, run_len);
        end else begin
          e = exp_q.pop_front();
          if (run_bc !== e.lvl || run_len != e.len)
            $display("FAIL seg%0d: got lvl=%0b len=%0d, want lvl=%0b len=%0d",
                     seg_idx, run_bc, run_len, e.lvl, e.len);
          else
            n_pass++;
        end
        if (!run_bc) begin
          if (seg_idx == 0) begin
            start_lo = run_len;
          end else begin
            rx_sh = {rx_sh[6:0], (run_len < start_lo)};
            if (seg_idx == 16) rx_q.push_back(rx_sh);
          end
        end
        seg_idx++;
        if (!bus.busy) in_frame = 0;
      end
      if (bus.busy) begin
        if (in_frame && !close_seg) begin
          run_len++;
        end else begin
          if (!in_frame) seg_idx = 0;
          in_frame = 1;
          run_bc   = bus.BC;
          run_len  = 1;
        end
      end
    end
  end

  function automatic int eff_pe(input int per);
    int pe;
    pe = per & ~3;
    if (pe < 16) pe = 16;
    return pe;
  endfunction

  task automatic push_exp(input logic [7:0] id, input int per);
    int pe;
    pe = eff_pe(per);
    exp_q.push_back('{1'b0, pe / 2});
    exp_q.push_back('{1'b1, pe / 2});
    for (int i = 7; i >= 0; i--) begin
      if (id[i]) begin
        exp_q.push_back('{1'b0, pe / 4});
        exp_q.push_back('{1'b1, 3 * pe / 4});
      end else begin
        exp_q.push_back('{1'b0, 3 * pe / 4});
        exp_q.push_back('{1'b1, pe / 4});
      end
    end
  endtask

  // Call at a negedge: sends, then runs until tx_done (bounded).
  task automatic run_frame(input logic [7:0] id, input int per,
                           input int chg_at, input int resend_at,
                           output int cyc, output int bcnt,
                           output logic first_busy);
    int pe;
    int n;
    pe = eff_pe(per);
    push_exp(id, per);
    bus.send   = 1'b1;
    bus.ID     = id;
    bus.period = per[21:0];
    @(negedge clk);
    bus.send   = 1'b0;
    first_busy = bus.busy;
    n    = 1;
    bcnt = 0;
    while (!bus.tx_done && n < 9 * pe + 50) begin
      if (bus.busy) bcnt++;
      if (n == chg_at) begin
        bus.ID     = 8'hFF;
        bus.period = 22'd64;
      end
      bus.send = (n == resend_at);
      @(negedge clk);
      n++;
    end
    bus.send = 1'b0;
    cyc = n - 1;
  endtask

  task automatic test_reset();
    int   cyc, bcnt;
    logic fb;
    repeat (3) @(negedge clk);
    n_chk++;
    if (bus.BC !== 1'b1) $display("FAIL reset_bc: got %b want 1", bus.BC);
    else n_pass++;
    n_chk++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy);
    else n_pass++;
    n_chk++;
    if (bus.tx_done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.tx_done);
    else n_pass++;
    rst_n = 1'b1;
    run_frame(8'hA5, 16, -1, -1, cyc, bcnt, fb);
    n_chk++;
    if (fb !== 1'b1) $display("FAIL first_edge_accept: busy %b want 1", fb);
    else n_pass++;
    n_chk++;
    if (cyc != 144) $display("FAIL first_frame_len: got %0d want 144", cyc);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_frame_timing();
    int   pers[3] = '{16, 7, 19};
    int   cyc, bcnt;
    logic fb;
    foreach (pers[i]) begin
      @(negedge clk);
      run_frame(8'hA5, pers[i], -1, -1, cyc, bcnt, fb);
      #1;
      n_chk++;
      if (cyc != 144) $display("FAIL done_cycle p=%0d: got %0d want 144", pers[i], cyc);
      else n_pass++;
      n_chk++;
      if (bcnt != 144) $display("FAIL busy_len p=%0d: got %0d want 144", pers[i], bcnt);
      else n_pass++;
      n_chk++;
      if (bus.BC !== 1'b1 || bus.busy !== 1'b0)
        $display("FAIL end_state p=%0d: bc=%b busy=%b want bc=1 busy=0", pers[i], bus.BC, bus.busy);
      else n_pass++;
      n_chk++;
      if (exp_q.size() != 0) $display("FAIL segs_left p=%0d: got %0d want 0", pers[i], exp_q.size());
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if (bus.tx_done !== 1'b0) $display("FAIL done_pulse p=%0d: got %b want 0", pers[i], bus.tx_done);
      else n_pass++;
    end
  endtask

  task automatic test_long_period();
    int   cyc, bcnt;
    logic fb;
    @(negedge clk);
    run_frame(8'h00, 400, -1, -1, cyc, bcnt, fb);
    #1;
    n_chk++;
    if (cyc != 3600) $display("FAIL long_len: got %0d want 3600", cyc);
    else n_pass++;
    n_chk++;
    if (exp_q.size() != 0) $display("FAIL long_segs_left: got %0d want 0", exp_q.size());
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_latch_ignore();
    int   cyc, bcnt, extra;
    logic fb;
    @(negedge clk);
    run_frame(8'h3C, 32, 20, 50, cyc, bcnt, fb);
    #1;
    n_chk++;
    if (cyc != 288) $display("FAIL latch_len: got %0d want 288", cyc);
    else n_pass++;
    n_chk++;
    if (exp_q.size() != 0) $display("FAIL latch_segs_left: got %0d want 0", exp_q.size());
    else n_pass++;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy) extra++;
    end
    n_chk++;
    if (extra != 0) $display("FAIL ignored_send: busy cycles %0d want 0", extra);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int   cyc, bcnt, bad;
    logic fb, bc_pre;
    @(negedge clk);
    push_exp(8'hA5, 128);
    bus.send   = 1'b1;
    bus.ID     = 8'hA5;
    bus.period = 22'd128;
    @(negedge clk);
    bus.send = 1'b0;
    repeat (59) @(negedge clk);
    bc_pre = bus.BC;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (bc_pre !== 1'b0) $display("FAIL pre_reset_bc: got %b want 0", bc_pre);
    else n_pass++;
    n_chk++;
    if (bus.BC !== 1'b1) $display("FAIL async_bc: got %b want 1", bus.BC);
    else n_pass++;
    n_chk++;
    if (bus.busy !== 1'b0) $display("FAIL async_busy: got %b want 0", bus.busy);
    else n_pass++;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.tx_done) bad++;
    end
    exp_q.delete();
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.tx_done || bus.busy) bad++;
    end
    n_chk++;
    if (bad != 0) $display("FAIL abort_quiet: got %0d active cycles want 0", bad);
    else n_pass++;
    run_frame(8'h3C, 16, -1, -1, cyc, bcnt, fb);
    #1;
    n_chk++;
    if (cyc != 144) $display("FAIL post_reset_len: got %0d want 144", cyc);
    else n_pass++;
    n_chk++;
    if (exp_q.size() != 0) $display("FAIL post_reset_segs: got %0d want 0", exp_q.size());
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] ids[3] = '{8'h00, 8'hFF, 8'h5A};
    int         cyc, bcnt;
    logic       fb;
    rx_q.delete();
    @(negedge clk);
    foreach (ids[i]) begin
      run_frame(ids[i], 64, -1, -1, cyc, bcnt, fb);
      n_chk++;
      if (fb !== 1'b1) $display("FAIL b2b_start%0d: busy %b want 1", i, fb);
      else n_pass++;
      n_chk++;
      if (cyc != 576) $display("FAIL b2b_len%0d: got %0d want 576", i, cyc);
      else n_pass++;
    end
    #1;
    n_chk++;
    if (rx_q.size() != 3) $display("FAIL rx_count: got %0d want 3", rx_q.size());
    else n_pass++;
    foreach (ids[i]) begin
      n_chk++;
      if (rx_q.size() <= i || rx_q[i] !== ids[i])
        $display("FAIL rx_id%0d: got %h want %h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, ids[i]);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  initial begin
    bus.send   = 1'b0;
    bus.ID     = 8'h00;
    bus.period = 22'd0;
    test_reset();
    test_frame_timing();
    test_long_period();
    test_latch_ignore();
    test_reset_mid_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/barcode_tx.md
BARCODE_TX -- requirements
Module: barcode_tx

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-003 SHALL have port send, input, 1, one-cycle-or-longer request to start a frame; sampled only in IDLE.
REQ-004 SHALL have port ID, input, 8, byte to transmit; captured on the accepted send.
REQ-005 SHALL have port period, input, 22, bit period P in clk cycles; captured on the accepted send.
REQ-006 SHALL have port BC, output, 1, serial barcode line; registered, idle high.
REQ-007 SHALL have port busy, output, 1, high from accepted send until frame end.
REQ-008 SHALL have port tx_done, output, 1, one-cycle pulse at frame end.

Function
REQ-009 SHALL encode each frame as one start bit followed by 8 data bits, MSB first, each of length P cycles.
REQ-010 SHALL drive the start bit low for P/2 cycles, then high for P/2 cycles.
REQ-011 SHALL begin every data bit with a falling edge; '1' low for P/4 cycles, then high for 3P/4; '0' low for 3P/4 cycles, then high for P/4.
REQ-012 SHALL use effective period Pe = {period[21:2],2'b00}; if Pe < 16, Pe SHALL be 16; P/2, P/4, 3P/4 derived by shift/add from Pe, no divider.
REQ-013 SHALL use states IDLE, START_LO, START_HI, BIT_LO, BIT_HI; IDLE->START_LO on send; START_LO->START_HI, START_HI->BIT_LO, BIT_LO->BIT_HI on phase-timer expiry; BIT_HI->BIT_LO on expiry with bits remaining, BIT_HI->IDLE on expiry after bit 0.
REQ-014 SHALL use one 22-bit down-counting phase timer loaded with the phase length minus 1 on every phase entry; phase ends when timer == 0.
REQ-015 SHALL use a 3-bit bit index starting at 7, decremented on each BIT_HI->BIT_LO transition.
REQ-016 SHALL latch ID and Pe in internal registers on the accepted send; later changes on ID/period SHALL not affect the frame in progress.
REQ-017 SHALL register BC: send high at edge k in IDLE -> BC = 0 and busy = 1 from edge k.
REQ-018 SHALL produce a frame lasting exactly 9*Pe cycles from edge k; BC = 1 and busy = 0 from edge k+9*Pe.
REQ-019 SHALL pulse tx_done high for exactly the one cycle following edge k+9*Pe.
REQ-020 SHALL ignore send while busy = 1; no queuing.
REQ-021 SHALL accept a new send in the same cycle tx_done is high; the next frame starts from that edge with no extra idle cycle.
REQ-022 SHALL keep BC glitch-free: BC changes only at phase boundaries, driven from a flop.

Reset
REQ-023 SHALL on rst_n low, asynchronously force BC = 1, busy = 0, tx_done = 0, state = IDLE, timer = 0, bit index = 7, latched ID = 0, latched Pe = 16.
REQ-024 SHALL on reset mid-frame abort the frame with no tx_done pulse; BC returns high immediately.
REQ-025 SHALL accept send on the first rising edge after rst_n deasserts.

Verification
REQ-026 SHALL cover: period = 16, ID = 0xA5, send pulse -> BC low 8/high 8; then bits 1,0,1,0,0,1,0,1 as low 4/high 12 ('1') and low 12/high 4 ('0'); tx_done at cycle 144; busy high for 144 cycles.
REQ-027 SHALL cover: period = 7 and period = 19 -> both produce Pe = 16 timing identical to REQ-026 for the same ID.
REQ-028 SHALL cover: period = 400, ID = 0x00 -> nine start/data bits totalling 3600 cycles, each data bit low 300/high 100.
REQ-029 SHALL cover: ID changed to 0xFF and period changed to 64 at cycle 20 of an 0x3C/P = 32 frame -> waveform still 0x3C at P = 32; second send at cycle 50 ignored.
REQ-030 SHALL cover: rst_n pulsed low at cycle 60 of a frame -> BC = 1, busy = 0 asynchronously; no tx_done pulse; new send after reset gives a correct full frame.
REQ-031 SHALL cover: loopback into the team's barcode receiver for ID = 0x00, 0xFF, 0x5A at P = 64 -> receiver ID equals sent ID, receiver ID_vld set once per frame, back-to-back sends per REQ-021.
